// File: rtl/pl_pkg.sv
// Shared constants, state encoding and helpers for the PC unit.
package pl_pkg;

   localparam logic [31:0] RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
   localparam int unsigned INC       = 4;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } pc_state_e;

   // True when the two low address bits select a word boundary.
   function automatic logic aligned4(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage

// File: rtl/pl_pc_next.sv
// Combinational next-PC selection: trap, aligned redirect, advance, hold.
module pl_pc_next #(
   parameter int unsigned    XLEN     = 32,
   parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(pl_pkg::TRAP_VEC),
   parameter int unsigned    INC      = pl_pkg::INC
) (
   input  logic [XLEN-1:0] pc,
   input  logic            trap,
   input  logic            redir,
   input  logic [XLEN-1:0] redir_tgt,
   input  logic            advance,
   output logic [XLEN-1:0] next_pc_c,
   output logic            taken_c,
   output logic            bad_redir_c
);

   import pl_pkg::*;

   // Priority mux; a misaligned redirect falls through to advance/hold.
   always_comb begin
      next_pc_c   = pc;
      taken_c     = 1'b0;
      bad_redir_c = 1'b0;
      if (trap) begin
         next_pc_c = TRAP_VEC;
         taken_c   = 1'b1;
      end else if (redir && aligned4(redir_tgt[1:0])) begin
         next_pc_c = redir_tgt;
         taken_c   = 1'b1;
      end else begin
         bad_redir_c = redir;
         if (advance) begin
            next_pc_c = pc + XLEN'(INC);
         end
      end
   end

endmodule

// File: rtl/pl_pc_unit.sv
// Program counter unit: boot sequencing, PC update, fetch request and counters.
module pl_pc_unit #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = XLEN'(pl_pkg::RESET_VEC),
   parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(pl_pkg::TRAP_VEC),
   parameter int unsigned     INC       = pl_pkg::INC,
   parameter int unsigned     CNT_W     = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             wpcir,
   input  logic             redir,
   input  logic [XLEN-1:0]  redir_tgt,
   input  logic             trap,
   output logic             if_req,
   output logic [XLEN-1:0]  if_addr,
   input  logic             if_gnt,
   output logic [XLEN-1:0]  pc,
   output logic             flush,
   output logic             misalign,
   output logic [CNT_W-1:0] fetch_cnt
);

   import pl_pkg::*;

   pc_state_e       state;
   logic [XLEN-1:0] next_pc_c;
   logic            taken_c;
   logic            bad_redir_c;
   logic            grant_c;
   logic            advance_c;

   // Fetch handshake is only live in RUN; if_gnt is ignored during BOOT.
   assign if_req    = (state == RUN);
   assign if_addr   = pc;
   assign grant_c   = if_req && if_gnt;
   assign advance_c = grant_c && wpcir;

   pl_pc_next #(
      .XLEN     (XLEN),
      .TRAP_VEC (TRAP_VEC),
      .INC      (INC)
   ) u_next (
      .pc          (pc),
      .trap        (trap),
      .redir       (redir),
      .redir_tgt   (redir_tgt),
      .advance     (advance_c),
      .next_pc_c   (next_pc_c),
      .taken_c     (taken_c),
      .bad_redir_c (bad_redir_c)
   );

   // State, PC, flush pulse, sticky misalign flag and grant counter.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= BOOT;
         pc        <= RESET_VEC;
         flush     <= 1'b0;
         misalign  <= 1'b0;
         fetch_cnt <= '0;
      end else begin
         state <= RUN;
         pc    <= next_pc_c;
         flush <= taken_c;
         if (bad_redir_c) begin
            misalign <= 1'b1;
         end
         if (grant_c) begin
            fetch_cnt <= fetch_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pl_pc_unit.sv
// Self-checking bench for pl_pc_unit: directed vectors with a fetch-address scoreboard.
module tb_pl_pc_unit;

   logic        clk = 1'b0;
   logic        clr;
   logic        wpcir, redir, trap, if_gnt;
   logic [31:0] redir_tgt;
   logic        if_req, flush, misalign;
   logic [31:0] if_addr, pc, fetch_cnt;

   logic        w_clr, w_wpcir, w_redir, w_trap, w_gnt;
   logic [31:0] w_tgt;
   logic        w_if_req, w_flush, w_misalign;
   logic [31:0] w_if_addr, w_pc;
   logic [1:0]  w_cnt;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   pl_pc_unit u_dut (
      .clk       (clk),
      .clr       (clr),
      .wpcir     (wpcir),
      .redir     (redir),
      .redir_tgt (redir_tgt),
      .trap      (trap),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .pc        (pc),
      .flush     (flush),
      .misalign  (misalign),
      .fetch_cnt (fetch_cnt)
   );

   pl_pc_unit #(.RESET_VEC(32'hFFFF_FFFC), .CNT_W(2)) u_wrap (
      .clk       (clk),
      .clr       (w_clr),
      .wpcir     (w_wpcir),
      .redir     (w_redir),
      .redir_tgt (w_tgt),
      .trap      (w_trap),
      .if_req    (w_if_req),
      .if_addr   (w_if_addr),
      .if_gnt    (w_gnt),
      .pc        (w_pc),
      .flush     (w_flush),
      .misalign  (w_misalign),
      .fetch_cnt (w_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs; queue the fetch address expected to be granted.
   task automatic step(input logic w, input logic r, input logic [31:0] t, input logic tr,
                       input logic g, input logic push, input logic [31:0] exp_addr);
      wpcir     = w;
      redir     = r;
      redir_tgt = t;
      trap      = tr;
      if_gnt    = g;
      if (push) exp_q.push_back(exp_addr);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every granted fetch must present the next queued address.
   always @(negedge clk) begin
      if (if_req && if_gnt) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: grant at if_addr 0x%08h with nothing queued", if_addr);
         end else begin
            chk("sb_if_addr", if_addr, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [31:0] wexp [5];
      wexp[0] = 32'h0; wexp[1] = 32'h4; wexp[2] = 32'h8; wexp[3] = 32'hC; wexp[4] = 32'h10;

      clr = 1'b1; wpcir = 1'b1; redir = 1'b0; trap = 1'b0; if_gnt = 1'b0; redir_tgt = '0;
      w_clr = 1'b1; w_wpcir = 1'b0; w_redir = 1'b0; w_trap = 1'b0; w_gnt = 1'b0; w_tgt = '0;

      // Reset and boot
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pc", pc, 32'h0);
      chk("rst_if_req", 32'(if_req), 32'h0);
      chk("rst_flush", 32'(flush), 32'h0);
      chk("rst_misalign", 32'(misalign), 32'h0);
      chk("rst_cnt", fetch_cnt, 32'h0);
      clr = 1'b0;
      step(1, 0, 0, 0, 1, 0, 0);
      chk("boot_if_req", 32'(if_req), 32'h1);
      chk("boot_pc", pc, 32'h0);
      chk("boot_cnt", fetch_cnt, 32'h0);
      step(1, 0, 0, 0, 1, 1, 32'h0);
      step(1, 0, 0, 0, 1, 1, 32'h4);
      step(1, 0, 0, 0, 1, 1, 32'h8);
      chk("boot_pc3", pc, 32'hC);
      chk("boot_cnt3", fetch_cnt, 32'd3);
      step(1, 0, 0, 0, 1, 1, 32'hC);

      // Stall then backpressure at 0x10
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 0, 0, 1, 1, 32'h10);
         chk("stall_pc", pc, 32'h10);
         chk("stall_if_addr", if_addr, 32'h10);
      end
      chk("stall_cnt", fetch_cnt, 32'd6);
      for (int i = 0; i < 2; i++) begin
         step(1, 0, 0, 0, 0, 0, 0);
         chk("bp_pc", pc, 32'h10);
         chk("bp_if_addr", if_addr, 32'h10);
      end
      chk("bp_cnt", fetch_cnt, 32'd6);
      step(1, 0, 0, 0, 1, 1, 32'h10);
      step(1, 0, 0, 0, 1, 1, 32'h14);
      step(1, 0, 0, 0, 1, 1, 32'h18);
      step(1, 0, 0, 0, 1, 1, 32'h1C);
      chk("run_pc", pc, 32'h20);
      chk("run_cnt", fetch_cnt, 32'd10);

      // Trap beats redirect and stall
      step(0, 1, 32'h80, 1, 0, 0, 0);
      chk("trap_pc", pc, 32'h100);
      chk("trap_flush", 32'(flush), 32'h1);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("trap_flush_end", 32'(flush), 32'h0);
      chk("trap_pc_hold", pc, 32'h100);
      step(1, 1, 32'h80, 0, 0, 0, 0);
      chk("redir_pc", pc, 32'h80);
      chk("redir_flush", 32'(flush), 32'h1);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("redir_flush_end", 32'(flush), 32'h0);

      // Misaligned redirect falls back to advance
      step(1, 1, 32'h30, 0, 0, 0, 0);
      chk("redir30_pc", pc, 32'h30);
      step(1, 1, 32'h42, 0, 1, 1, 32'h30);
      chk("mis_pc", pc, 32'h34);
      chk("mis_flag", 32'(misalign), 32'h1);
      chk("mis_flush", 32'(flush), 32'h0);
      chk("mis_cnt", fetch_cnt, 32'd11);
      step(1, 0, 0, 0, 1, 1, 32'h34);
      chk("mis_sticky", 32'(misalign), 32'h1);
      chk("mis_pc2", pc, 32'h38);

      // Asynchronous reset mid-cycle during flush with a pending fetch
      step(1, 1, 32'h200, 0, 0, 0, 0);
      chk("pre_clr_flush", 32'(flush), 32'h1);
      chk("pre_clr_pc", pc, 32'h200);
      #2;
      clr = 1'b1;
      #1;
      chk("aclr_pc", pc, 32'h0);
      chk("aclr_if_addr", if_addr, 32'h0);
      chk("aclr_if_req", 32'(if_req), 32'h0);
      chk("aclr_flush", 32'(flush), 32'h0);
      chk("aclr_misalign", 32'(misalign), 32'h0);
      chk("aclr_cnt", fetch_cnt, 32'h0);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("sb_drain", 32'(exp_q.size()), 32'h0);

      // Address and counter wrap on the second instance
      w_clr = 1'b0; w_gnt = 1'b1; w_wpcir = 1'b1;
      chk("wrap_boot_pc", w_pc, 32'hFFFF_FFFC);
      chk("wrap_boot_req", 32'(w_if_req), 32'h0);
      @(posedge clk);
      #1;
      chk("wrap_run_pc", w_pc, 32'hFFFF_FFFC);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("wrap_pc", w_pc, wexp[i]);
      end
      chk("wrap_cnt", 32'(w_cnt), 32'd1);
      chk("wrap_misalign", 32'(w_misalign), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pl_pc_unit.md
PL_PC_UNIT -- requirements
Module: pl_pc_unit

Interface
REQ-001 SHALL have parameters, one per line:
- XLEN, 32, PC/address width.
- RESET_VEC, 32'h0000_0000, PC value loaded by reset.
- TRAP_VEC, 32'h0000_0100, PC value loaded on trap.
- INC, 4, sequential PC increment.
- CNT_W, 32, fetch counter width.

REQ-002 SHALL have ports, one per line (name direction width meaning):
- clk  in  1  sole clock; all state updates on its rising edge.
- clr  in  1  asynchronous, active-high reset.
- wpcir  in  1  PC write enable; 0 = pipeline stall.
- redir  in  1  branch/jump redirect request.
- redir_tgt  in  XLEN  redirect target address.
- trap  in  1  trap request.
- if_req  out  1  fetch request to instruction memory.
- if_addr  out  XLEN  fetch address; always equals pc.
- if_gnt  in  1  fetch accepted in this cycle.
- pc  out  XLEN  current PC.
- flush  out  1  one-cycle pulse after a taken redirect or trap.
- misalign  out  1  sticky flag: redirect target not 4-byte aligned.
- fetch_cnt  out  CNT_W  count of granted fetches.

Function
REQ-003 SHALL implement states BOOT and RUN; BOOT is entered on reset, and BOOT -> RUN happens on the first clk edge with clr low.
REQ-004 SHALL drive if_req=0 in BOOT and if_req=1 in RUN.
REQ-005 SHALL resolve the next PC per edge in priority order: trap, then valid redirect, then advance, then hold.
- trap=1: pc <= TRAP_VEC.
- redir=1 and redir_tgt[1:0]==0: pc <= redir_tgt.
- RUN and wpcir=1 and if_gnt=1: pc <= pc + INC.
- Otherwise: pc unchanged.
REQ-006 SHALL apply trap and redirect regardless of wpcir, if_gnt and state.
REQ-007 SHALL treat redir=1 with redir_tgt[1:0]!=0 (and trap=0) as a misaligned redirect: pc is not updated by it, the advance/hold rule applies instead, and misalign is set to 1.
REQ-008 SHALL keep misalign at 1 until reset.
REQ-009 SHALL assert flush for exactly the one cycle following any edge at which a trap or valid redirect updated pc.
REQ-010 SHALL hold pc and if_addr stable while if_req=1 and if_gnt=0, unless a trap or redirect occurs.
REQ-011 SHALL increment fetch_cnt by 1 on each edge with if_req=1 and if_gnt=1, independent of wpcir and of redirect.
REQ-012 SHALL let fetch_cnt wrap from all-ones to 0 without any flag.
REQ-013 SHALL compute pc + INC modulo 2^XLEN, so wrap-around at the top of the address space is silent.
REQ-014 SHALL ignore if_gnt while in BOOT.
REQ-015 SHALL produce if_addr combinationally from pc and have zero latency from a pc update to if_addr.

Reset
REQ-016 SHALL, while clr=1, asynchronously force: state=BOOT, pc=RESET_VEC, flush=0, misalign=0, fetch_cnt=0.
REQ-017 SHALL, if clr asserts mid-operation (including during a pending ungranted fetch or the flush cycle), discard all pending activity with no residual effect.
REQ-018 SHALL synchronise no input internally; clr deassertion timing is the integrator's responsibility.

Structure
REQ-019 SHALL place RESET_VEC, TRAP_VEC, INC and the state encoding (BOOT=1'b0, RUN=1'b1) in a shared package, pl_pkg.
REQ-020 SHALL contain one sub-module, pl_pc_next: a combinational next-PC priority mux implementing REQ-005 and REQ-007.
REQ-021 SHALL keep all state registers in pl_pc_unit.

Verification
REQ-022 Reset and boot: assert clr for 3 cycles, then release with if_gnt=1 -> pc=0x0, if_req=0 for one cycle, then if_req=1; after 3 grants pc=0xC and fetch_cnt=3.
REQ-023 Stall and backpressure: at pc=0x10, drive wpcir=0 for 2 cycles, then wpcir=1 with if_gnt=0 for 2 cycles -> pc and if_addr stay 0x10 throughout; fetch_cnt increments only on cycles where if_gnt=1.
REQ-024 Priority: at pc=0x20, drive trap=1, redir=1, redir_tgt=0x80 and wpcir=0 in the same cycle -> pc=0x100 and flush=1 for exactly one cycle; a lone redirect to 0x80 gives pc=0x80.
REQ-025 Misalignment: drive redir=1, redir_tgt=0x42 at pc=0x30 with wpcir=1 and if_gnt=1 -> pc=0x34, misalign=1 and remains 1, flush stays 0.
REQ-026 Wrap: with RESET_VEC=0xFFFF_FFFC and CNT_W=2, issue 5 grants -> pc sequence 0xFFFF_FFFC, 0x0, 0x4, 0x8, 0xC, 0x10, and fetch_cnt ends at 1.
REQ-027 Mid-operation reset: assert clr asynchronously mid-cycle during flush=1 with if_req=1 and if_gnt=0 -> all outputs return to reset values immediately, without waiting for a clk edge.
